// File: rtl/palette_fade_lut.sv
// Writable colour palette with a 2-stage lookup pipeline and a frame-synchronous brightness fade engine.
// Optional transparency on index TRANSP_IDX when PALETTE_TRANSP_EN is defined.
module palette_fade_lut #(
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned CH_W        = 4,
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned TRANSP_IDX  = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [IDX_W-1:0]  index,
  input  logic              index_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              pix_valid,
  output logic              pix_opaque,
  output logic              fade_busy,
  output logic              fade_done,
  output logic [CH_W:0]     level
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);
  localparam logic [CH_W:0] FULL = {1'b1, {CH_W{1'b0}}};

  // Parameter sanity, evaluated at elaboration only.
  if (STEP_FRAMES < 1) begin : g_bad_step
    $error("STEP_FRAMES must be at least 1");
  end
  if (TRANSP_IDX >= DEPTH) begin : g_bad_transp
    $error("TRANSP_IDX must address a palette entry");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3*CH_W-1:0] grey(input int unsigned i);
    logic [CH_W-1:0] c;
    c = CH_W'(i);
    return {c, c, c};
  endfunction

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] chan,
                                            input logic [CH_W:0]   lvl);
    logic [2*CH_W:0] prod;
    prod = {{(CH_W + 1){1'b0}}, chan} * {{CH_W{1'b0}}, lvl};
    return CH_W'(prod >> CH_W);
  endfunction

  // ---------------------------------------------------------------------------
  // Palette storage (flops, so reset can restore the greyscale ramp)
  // ---------------------------------------------------------------------------
  logic [3*CH_W-1:0] pal [DEPTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pal[i] <= grey(i);
      end
    end else if (wr_en) begin
      pal[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: palette read (sees pre-write contents, giving read-before-write)
  // ---------------------------------------------------------------------------
  logic [3*CH_W-1:0] s1_col;
  logic              s1_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_col   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_col   <= pal[index];
      s1_valid <= index_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: brightness scaling against the live fade level
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] r_scaled;
  logic [CH_W-1:0] g_scaled;
  logic [CH_W-1:0] b_scaled;

  always_comb begin
    r_scaled = scale(s1_col[3*CH_W-1:2*CH_W], level);
    g_scaled = scale(s1_col[2*CH_W-1:CH_W], level);
    b_scaled = scale(s1_col[CH_W-1:0], level);
  end

`ifdef PALETTE_TRANSP_EN
  logic s1_transp;
  logic opaque_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_transp <= 1'b0;
    end else begin
      s1_transp <= (index == IDX_W'(TRANSP_IDX));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pix_valid <= 1'b0;
      opaque_q  <= 1'b1;
    end else begin
      pix_valid <= s1_valid;
      if (s1_valid) begin
        if (s1_transp) begin
          red      <= '0;
          green    <= '0;
          blue     <= '0;
          opaque_q <= 1'b0;
        end else begin
          red      <= r_scaled;
          green    <= g_scaled;
          blue     <= b_scaled;
          opaque_q <= 1'b1;
        end
      end
    end
  end

  assign pix_opaque = opaque_q;
`else
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= s1_valid;
      if (s1_valid) begin
        red   <= r_scaled;
        green <= g_scaled;
        blue  <= b_scaled;
      end
    end
  end

  assign pix_opaque = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Fade engine
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_n;
  logic [CH_W:0]    level_n;
  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] fcnt_n;
  logic             dir_q;
  logic             dir_n;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      level <= FULL;
      fcnt  <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      fcnt  <= fcnt_n;
      dir_q <= dir_n;
    end
  end

  always_comb begin
    state_n   = state;
    level_n   = level;
    fcnt_n    = fcnt;
    dir_n     = dir_q;
    fade_busy = (state != IDLE);
    fade_done = (state == DONE);
    unique case (state)
      IDLE: begin
        // Frame pulses are not counted here, even one coincident with fade_start.
        if (fade_start) begin
          dir_n  = fade_dir;
          fcnt_n = '0;
          if (fade_dir ? (level == FULL) : (level == '0)) begin
            state_n = DONE;
          end else begin
            state_n = STEP;
          end
        end
      end
      STEP: begin
        if (frame_start) begin
          if (fcnt == CNT_LAST) begin
            fcnt_n = '0;
            if (dir_q) begin
              if (level != FULL) level_n = level + 1'b1;
            end else begin
              if (level != '0) level_n = level - 1'b1;
            end
            if (dir_q ? (level_n == FULL) : (level_n == '0)) begin
              state_n = DONE;
            end
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
